// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO bytes and packs RATIO of them little-endian onto a valid/ready word stream
// Define RD_PACKER_STATS_EN to add the word_cnt/partial_cnt handshake counters.
module fifo_rd_packer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int RATIO      = 4,
    localparam int OUT_WIDTH  = DATA_WIDTH * RATIO
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [RATIO-1:0]      out_keep
`ifdef RD_PACKER_STATS_EN
    ,
    output logic [15:0]           word_cnt,
    output logic [7:0]            partial_cnt
`endif
);

    localparam int CW = $clog2(RATIO + 1);
    localparam logic [CW-1:0] L_RATIO_C = CW'(RATIO);
    localparam logic [CW:0]   L_RATIO   = (CW + 1)'(RATIO);

    logic [RATIO-1:0][DATA_WIDTH-1:0] r_pack;
    logic [CW-1:0]                    r_cnt;
    logic                             r_pend;
    logic                             r_flush_req;

    logic                             w_slot_free;
    logic                             w_xfer;
    logic [CW-1:0]                    w_cnt_eff;
    logic [CW:0]                      w_fill;
    logic                             w_flush_part;
    logic                             w_flush_done;
    logic [RATIO-1:0][DATA_WIDTH-1:0] w_part_data;
    logic [RATIO-1:0]                 w_part_keep;

    always_comb begin
        w_slot_free = !out_valid || out_ready;
        w_xfer      = (r_cnt == L_RATIO_C) && w_slot_free;
        w_cnt_eff   = w_xfer ? '0 : r_cnt;
        // Lanes already owned plus a byte still in flight must fit in the word.
        w_fill      = {1'b0, w_cnt_eff} + {{CW{1'b0}}, r_pend};
        fifo_r_en   = rrst_n && !fifo_empty && !r_flush_req && !flush && (w_fill < L_RATIO);

        w_flush_part = r_flush_req && !r_pend && (r_cnt != '0) && (r_cnt < L_RATIO_C) && w_slot_free;
        w_flush_done = r_flush_req && !r_pend && ((r_cnt == '0) || w_flush_part || w_xfer);

        w_part_data = '0;
        w_part_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            w_part_keep[i] = (CW'(i) < r_cnt);
            w_part_data[i] = w_part_keep[i] ? r_pack[i] : '0;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_pack      <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_flush_req <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_keep    <= '0;
        end else begin
            r_pend <= fifo_r_en;

            // A flush arriving while one is outstanding is absorbed.
            if (r_flush_req)
                r_flush_req <= !w_flush_done;
            else
                r_flush_req <= flush;

            if (r_pend) begin
                for (int i = 0; i < RATIO; i++) begin
                    if (w_cnt_eff == CW'(i))
                        r_pack[i] <= fifo_data;
                end
                r_cnt <= w_cnt_eff + 1'b1;
            end else if (w_flush_part) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_eff;
            end

            if (w_xfer) begin
                out_valid <= 1'b1;
                out_data  <= r_pack;
                out_keep  <= '1;
            end else if (w_flush_part) begin
                out_valid <= 1'b1;
                out_data  <= w_part_data;
                out_keep  <= w_part_keep;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RD_PACKER_STATS_EN
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            word_cnt    <= '0;
            partial_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (word_cnt != 16'hFFFF)
                word_cnt <= word_cnt + 16'd1;
            if ((out_keep != '1) && (partial_cnt != 8'hFF))
                partial_cnt <= partial_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - scoreboard bench: FIFO model feeds the packer, monitor checks each accepted word
module tb_fifo_rd_packer;

    logic        rclk;
    logic        rrst_n;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_r_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
`ifdef RD_PACKER_STATS_EN
    logic [15:0] word_cnt;
    logic [7:0]  partial_cnt;
`endif

    fifo_rd_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep)
`ifdef RD_PACKER_STATS_EN
        ,
        .word_cnt   (word_cnt),
        .partial_cnt(partial_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } word_t;

    logic [7:0] fifo_q[$];
    word_t      exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         pops    = 0;
    logic       r_en_s  = 1'b0;
    logic       hold    = 1'b0;
    logic [31:0] held   = '0;

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_bytes(input logic [7:0] b[$]);
        foreach (b[i]) fifo_q.push_back(b[i]);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        word_t w;
        w.data = d;
        w.keep = k;
        exp_q.push_back(w);
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_pops(input string name, input int target);
        int n = 0;
        while (pops < target && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_pops"}, 32'(pops), 32'(target));
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // FIFO model: registered empty flag, data one cycle after an accepted read.
    always @(negedge rclk) begin
        r_en_s = fifo_r_en;
        if (fifo_r_en && fifo_empty) begin
            n_tests++;
            n_fail++;
            $display("FAIL underflow: r_en=1 while empty=1");
        end
    end

    always @(posedge rclk) begin
        if (r_en_s) begin
            if (fifo_q.size() != 0)
                fifo_data <= fifo_q.pop_front();
            pops++;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor: compares every accepted word against the scoreboard and checks hold stability.
    always @(negedge rclk) begin
        if (rrst_n) begin
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h keep %0h expected none", out_data, out_keep);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("word_data", out_data, w.data);
                    chk("word_keep", 32'(out_keep), 32'(w.keep));
                end
            end
            hold = out_valid && !out_ready;
            held = out_data;
        end else begin
            hold = 1'b0;
        end
    end

    initial begin
        int base;
        rrst_n     = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_keep", 32'(out_keep), 32'd0);
        chk("rst_ren", 32'(fifo_r_en), 32'd0);
        rrst_n = 1'b1;
        tick();

        // Streaming
        base = pops;
        out_ready = 1'b1;
        push_bytes('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
        expect_word(32'h04030201, 4'hF);
        expect_word(32'h08070605, 4'hF);
        drain("stream", 100);
        repeat (4) tick();
        chk("stream_pops", 32'(pops - base), 32'd8);
        chk("stream_ren_idle", 32'(fifo_r_en), 32'd0);

        // Backpressure
        base = pops;
        out_ready = 1'b0;
        push_bytes('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                     8'h09, 8'h0A, 8'h0B, 8'h0C});
        expect_word(32'h04030201, 4'hF);
        expect_word(32'h08070605, 4'hF);
        expect_word(32'h0C0B0A09, 4'hF);
        repeat (20) tick();
        chk("bp_pops", 32'(pops - base), 32'd8);
        chk("bp_ren_stall", 32'(fifo_r_en), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_data", out_data, 32'h04030201);
        out_ready = 1'b1;
        drain("bp", 100);

        // Flush partial, then flush with nothing packed
        push_bytes('{8'hAA, 8'hBB, 8'hCC});
        repeat (8) tick();
        expect_word(32'h00CCBBAA, 4'b0111);
        pulse_flush();
        drain("flush_part", 20);
        pulse_flush();
        repeat (6) tick();
        chk("flush_empty_novalid", 32'(out_valid), 32'd0);

        // Flush in the cycle after the read for byte 2
        base = pops;
        push_bytes('{8'h51, 8'h52, 8'h53});
        wait_pops("fpend", base + 2);
        flush = 1'b1;
        expect_word(32'h00005251, 4'b0011);
        tick();
        flush = 1'b0;
        chk("fpend_ren_blocked", 32'(fifo_r_en), 32'd0);
        chk("fpend_no_more_pops", 32'(pops - base), 32'd2);
        drain("fpend", 20);
        wait_pops("fpend_resume", base + 3);
        repeat (3) tick();
        expect_word(32'h00000053, 4'b0001);
        pulse_flush();
        drain("fpend_tail", 20);

        // Reset mid-word
        base = pops;
        push_bytes('{8'h61, 8'h62});
        wait_pops("rstmid", base + 2);
        tick();
        rrst_n = 1'b0;
        chk("rstmid_ren", 32'(fifo_r_en), 32'd0);
        tick();
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_data", out_data, 32'd0);
        chk("rstmid_keep", 32'(out_keep), 32'd0);
        rrst_n = 1'b1;
        push_bytes('{8'h11, 8'h22, 8'h33, 8'h44});
        expect_word(32'h44332211, 4'hF);
        drain("rstmid", 100);

`ifdef RD_PACKER_STATS_EN
        rrst_n = 1'b0;
        tick();
        chk("stats_rst_words", 32'(word_cnt), 32'd0);
        rrst_n = 1'b1;
        base = pops;
        push_bytes('{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87,
                     8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C});
        expect_word(32'h83828180, 4'hF);
        expect_word(32'h87868584, 4'hF);
        expect_word(32'h8B8A8988, 4'hF);
        wait_pops("stats", base + 13);
        repeat (4) tick();
        expect_word(32'h0000008C, 4'b0001);
        pulse_flush();
        drain("stats", 50);
        repeat (2) tick();
        chk("stats_word_cnt", 32'(word_cnt), 32'd4);
        chk("stats_partial_cnt", 32'(partial_cnt), 32'd1);
`endif

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
